// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

   // Widest payload the parity helper covers; words are zero-extended to this.
   localparam int MAX_WORD_W = 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Even-parity bit: 1 when the word holds an odd number of ones, so that
   // data plus parity always carries an even count. Zero-extension is harmless.
   function automatic logic even_parity(input logic [MAX_WORD_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit and flags the last one.
module serial_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_tick
);

   localparam int PCW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [PCW-1:0] LAST_CLK = PCW'(CLKS_PER_BIT - 1);
   localparam logic [PCW-1:0] CNT_ONE  = PCW'(1'b1);
   localparam logic [PCW-1:0] CNT_ZERO = {PCW{1'b0}};

   logic [PCW-1:0] period_cnt_r;

   assign bit_tick = (period_cnt_r == LAST_CLK);

   // Period counter: wraps at every bit boundary, realigned when a frame is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_cnt_r <= CNT_ZERO;
      end else if (restart || bit_tick) begin
         period_cnt_r <= CNT_ZERO;
      end else begin
         period_cnt_r <= period_cnt_r + CNT_ONE;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, data LSB first, optional even parity, stop bit.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BCW = $clog2(DATA_W + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
   localparam logic [BCW-1:0] BIT_ONE  = BCW'(1'b1);
   localparam logic [BCW-1:0] BIT_ZERO = {BCW{1'b0}};

   tx_state_t         state_r, state_next_s;
   logic [DATA_W-1:0] shift_r, shift_next_s;
   logic [BCW-1:0]    bit_cnt_r, bit_cnt_next_s;
   logic              parity_r, parity_next_s;
   logic              tx_r, tx_next_s;
   logic              bit_tick_s;
   logic              restart_s;
   logic              accept_s;

   serial_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (restart_s),
      .bit_tick(bit_tick_s)
   );

   // Status decodes of registered state; the last STOP cycle opens the input
   // so the next frame can follow without an idle-high gap.
   assign busy     = (state_r != IDLE);
   assign done     = (state_r == STOP) && bit_tick_s;
   assign in_ready = !busy || done;
   assign accept_s = in_valid && in_ready;
   assign tx       = tx_r;

   // Next-state logic: frame sequencing, word capture and shifting.
   always_comb begin
      state_next_s   = state_r;
      shift_next_s   = shift_r;
      bit_cnt_next_s = bit_cnt_r;
      parity_next_s  = parity_r;
      restart_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s   = START;
               shift_next_s   = in_data;
               parity_next_s  = even_parity(MAX_WORD_W'(in_data));
               bit_cnt_next_s = BIT_ZERO;
               restart_s      = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            if (bit_tick_s) begin
               state_next_s   = DATA;
               bit_cnt_next_s = BIT_ZERO;
            end else begin
               state_next_s = START;
            end
         end
         DATA: begin
            if (bit_tick_s) begin
               shift_next_s = shift_r >> 1'b1;
               if (bit_cnt_r == LAST_BIT) begin
                  state_next_s   = (PARITY_EN != 0) ? PARITY : STOP;
                  bit_cnt_next_s = BIT_ZERO;
               end else begin
                  bit_cnt_next_s = bit_cnt_r + BIT_ONE;
               end
            end else begin
               state_next_s = DATA;
            end
         end
         PARITY: begin
            if (bit_tick_s) begin
               state_next_s = STOP;
            end else begin
               state_next_s = PARITY;
            end
         end
         STOP: begin
            if (bit_tick_s) begin
               if (accept_s) begin
                  state_next_s   = START;
                  shift_next_s   = in_data;
                  parity_next_s  = even_parity(MAX_WORD_W'(in_data));
                  bit_cnt_next_s = BIT_ZERO;
                  restart_s      = 1'b1;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = STOP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Line value for the upcoming cycle, registered so tx is glitch-free.
   always_comb begin
      tx_next_s = LINE_IDLE;
      case (state_next_s)
         IDLE:    tx_next_s = LINE_IDLE;
         START:   tx_next_s = START_BIT;
         DATA:    tx_next_s = shift_next_s[0];
         PARITY:  tx_next_s = parity_next_s;
         STOP:    tx_next_s = STOP_BIT;
         default: tx_next_s = LINE_IDLE;
      endcase
   end

   // State, datapath and output registers; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         shift_r   <= {DATA_W{1'b0}};
         bit_cnt_r <= BIT_ZERO;
         parity_r  <= 1'b0;
         tx_r      <= LINE_IDLE;
      end else begin
         state_r   <= state_next_s;
         shift_r   <= shift_next_s;
         bit_cnt_r <= bit_cnt_next_s;
         parity_r  <= parity_next_s;
         tx_r      <= tx_next_s;
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: default build (A) and parity, one-clock-per-bit build (B).
module tb_serial_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic       a_reset, a_valid, a_ready, a_tx, a_busy, a_done;
   logic [7:0] a_data;
   logic       b_reset, b_valid, b_ready, b_tx, b_busy, b_done;
   logic [7:0] b_data;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
      .clk(clk), .reset(a_reset), .in_data(a_data), .in_valid(a_valid),
      .in_ready(a_ready), .tx(a_tx), .busy(a_busy), .done(a_done)
   );

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_b (
      .clk(clk), .reset(b_reset), .in_data(b_data), .in_valid(b_valid),
      .in_ready(b_ready), .tx(b_tx), .busy(b_busy), .done(b_done)
   );

   // Expected frames as transmitted bit sequences, first bit on the left.
   string a_exp_q[$];
   string b_exp_q[$];
   int    a_done_cyc[$];
   int    b_done_cyc[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_frame(string tag, string e, int cpb, input logic cap [0:255], int len);
      int bad = 0;
      check({tag, "_frame_len"}, len, e.len() * cpb);
      for (int i = 0; i < len && i < 256 && i < e.len() * cpb; i++) begin
         if (cap[i] !== (e[i / cpb] == 8'h31)) bad++;
      end
      check({tag, "_frame_bit_errors"}, bad, 0);
   endtask

   // Monitor A: record tx while busy, compare against the scoreboard at each done.
   logic a_cap [0:255];
   int   a_len = 0;
   always @(negedge clk) begin
      if (a_busy === 1'b1) begin
         if (a_len < 256) a_cap[a_len] = a_tx;
         a_len++;
      end else begin
         a_len = 0;
      end
      if (a_done === 1'b1) begin
         a_done_cyc.push_back(cyc);
         if (a_exp_q.size() == 0) check("a_unexpected_done", 1, 0);
         else check_frame("a", a_exp_q.pop_front(), 4, a_cap, a_len);
         a_len = 0;
      end
   end

   // Monitor B: same scheme for the parity build.
   logic b_cap [0:255];
   int   b_len = 0;
   always @(negedge clk) begin
      if (b_busy === 1'b1) begin
         if (b_len < 256) b_cap[b_len] = b_tx;
         b_len++;
      end else begin
         b_len = 0;
      end
      if (b_done === 1'b1) begin
         b_done_cyc.push_back(cyc);
         if (b_exp_q.size() == 0) check("b_unexpected_done", 1, 0);
         else check_frame("b", b_exp_q.pop_front(), 1, b_cap, b_len);
         b_len = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wait_done(int n_before, int budget);
      int k = 0;
      while (a_done_cyc.size() == n_before && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("a_done_seen", a_done_cyc.size() > n_before, 1);
   endtask

   task automatic b_wait_done(int n_before, int budget);
      int k = 0;
      while (b_done_cyc.size() == n_before && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("b_done_seen", b_done_cyc.size() > n_before, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int n;
      int bad_ready;

      // Reset held two edges with a word offered: nothing may start.
      a_reset = 1'b1; a_valid = 1'b1; a_data = 8'hFF;
      b_reset = 1'b1; b_valid = 1'b1; b_data = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check("a_rst_tx", a_tx, 1);  check("a_rst_ready", a_ready, 1);
      check("a_rst_busy", a_busy, 0); check("a_rst_done", a_done, 0);
      check("b_rst_tx", b_tx, 1);  check("b_rst_ready", b_ready, 1);
      check("b_rst_busy", b_busy, 0); check("b_rst_done", b_done, 0);
      a_valid = 1'b0; a_reset = 1'b0;
      b_valid = 1'b0; b_reset = 1'b0;
      tick();
      check("a_no_frame_after_reset", a_busy, 0);
      check("a_idle_line", a_tx, 1);

      // Single frame 0xA5: done in the 40th cycle after the accept.
      n = a_done_cyc.size();
      a_data = 8'hA5; a_valid = 1'b1;
      a_exp_q.push_back("0101001011");
      tick();
      acc = cyc;   // value seen during cycle 1 after the accept
      a_valid = 1'b0;
      check("a_start_latency_tx", a_tx, 0);
      check("a_start_latency_busy", a_busy, 1);
      a_wait_done(n, 100);
      check("a_A5_done_cycle", a_done_cyc[n] - acc, 39);
      tick();
      check("a_after_frame_busy", a_busy, 0);
      check("a_after_frame_tx", a_tx, 1);
      check("a_after_frame_ready", a_ready, 1);

      // Back-to-back 0x00 then 0xFF with in_valid held.
      n = a_done_cyc.size();
      a_data = 8'h00; a_valid = 1'b1;
      a_exp_q.push_back("0000000001");
      a_exp_q.push_back("0111111111");
      tick();
      a_data = 8'hFF;
      a_wait_done(n, 100);
      tick();
      a_valid = 1'b0;
      check("a_b2b_start_tx", a_tx, 0);
      check("a_b2b_busy", a_busy, 1);
      a_wait_done(n + 1, 100);
      check("a_b2b_done_spacing", a_done_cyc[n + 1] - a_done_cyc[n], 40);
      tick();

      // 0x81 frame with a stray 0x3C offer in cycle 10.
      n = a_done_cyc.size();
      bad_ready = 0;
      a_data = 8'h81; a_valid = 1'b1;
      a_exp_q.push_back("0100000011");
      tick();
      a_valid = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         if (j == 10) begin
            a_valid = 1'b1; a_data = 8'h3C;
         end else if (j == 11) begin
            a_valid = 1'b0;
         end
         if (a_ready !== (j == 40)) bad_ready++;
         if (j < 40) tick();
      end
      check("a_ignore_ready_errors", bad_ready, 0);
      tick();
      check("a_ignore_one_done", a_done_cyc.size() - n, 1);
      check("a_ignore_idle", a_busy, 0);

      // Reset in cycle 15 of a 0x55 frame: aborted, no done.
      n = a_done_cyc.size();
      a_data = 8'h55; a_valid = 1'b1;
      a_exp_q.push_back("0101010101");
      tick();
      a_valid = 1'b0;
      repeat (14) tick();
      check("a_midframe_busy_before", a_busy, 1);
      a_reset = 1'b1;
      a_exp_q.delete();
      tick();
      check("a_midrst_tx", a_tx, 1);
      check("a_midrst_busy", a_busy, 0);
      check("a_midrst_ready", a_ready, 1);
      check("a_midrst_done", a_done, 0);
      a_reset = 1'b0;
      repeat (50) tick();
      check("a_midrst_no_done", a_done_cyc.size() - n, 0);
      check("a_midrst_line_idle", a_tx, 1);

      // Parity build: 0x07 (odd ones, parity 1), done in cycle 11.
      n = b_done_cyc.size();
      b_data = 8'h07; b_valid = 1'b1;
      b_exp_q.push_back("01110000011");
      tick();
      acc = cyc;
      b_valid = 1'b0;
      check("b_start_latency_tx", b_tx, 0);
      b_wait_done(n, 50);
      check("b_07_done_cycle", b_done_cyc[n] - acc, 10);
      tick();

      // Parity build: 0x03 (even ones, parity 0).
      n = b_done_cyc.size();
      b_data = 8'h03; b_valid = 1'b1;
      b_exp_q.push_back("01100000001");
      tick();
      b_valid = 1'b0;
      b_wait_done(n, 50);
      tick();
      check("b_after_frame_busy", b_busy, 0);

      check("a_scoreboard_drained", a_exp_q.size(), 0);
      check("b_scoreboard_drained", b_exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
